key_schedule_sequencer: RTL and testbench

KEY_SCHEDULE_SEQUENCER -- requirements
Module: key_schedule_sequencer

---
 rtl/key_schedule_sequencer.sv | 48 ++++
 tb/tb_key_schedule_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/key_schedule_sequencer.sv
// key_schedule_sequencer: drives an external single-round key-step and stores every round key.
module key_schedule_sequencer #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         clear,
  output logic [3:0]   step_round,
  output logic [127:0] step_key,
  input  logic [127:0] step_result,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] store [NUM_ROUNDS+1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == EXPAND) begin
      store[cnt + 4'd1] <= step_result;
      if (cnt == 4'(NUM_ROUNDS - 1)) state <= DONE;
      else cnt <= cnt + 4'd1;
    end else if (key_valid) begin
      store[0] <= key_in;
      cnt      <= '0;
      state    <= EXPAND;
    end
  end
  assign key_ready  = state != EXPAND;
  assign busy       = state == EXPAND;
  assign done       = state == DONE;
  assign step_round = busy ? cnt : 4'd0;
  assign step_key   = busy ? store[cnt] : store[0];
  // Indices past the last round key read as zero rather than aliasing.
  assign rd_key     = 32'(rd_addr) <= NUM_ROUNDS ? store[rd_addr] : 128'h0;
endmodule

// File: tb/tb_key_schedule_sequencer.sv
// tb_key_schedule_sequencer: directed checks of the key schedule sequencer with a +1 key-step stub.
module tb_key_schedule_sequencer;
  logic         clk = 0, rst = 0, key_valid = 0, clear = 0;
  logic [127:0] key_in = '0, step_key, step_result, rd_key;
  logic [3:0]   step_round, rd_addr = '0;
  logic         key_ready, busy, done;
  int           total = 0, bad = 0;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [16];

  key_schedule_sequencer dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .clear(clear), .step_round(step_round), .step_key(step_key), .step_result(step_result),
    .rd_addr(rd_addr), .rd_key(rd_key), .busy(busy), .done(done)
  );

  assign step_result = step_key + 128'd1;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [127:0] exp);
    rd_addr = a;
    #1;
    check(name, rd_key, exp);
  endtask

  task automatic start(input logic [127:0] k);
    @(negedge clk);
    key_valid = 1;
    key_in = k;
    @(negedge clk);
    key_valid = 0;
  endtask

  // Checks one full expansion cycle by cycle; noise=1 keeps offering a bogus key throughout.
  task automatic expand(input string name, input bit noise);
    for (int i = 0; i < 10; i++) begin
      check({name, " busy"}, 128'(busy), 128'd1);
      check({name, " round"}, 128'(step_round), 128'(i));
      key_valid = noise;
      key_in = 128'hDEAD;
      @(negedge clk);
    end
    key_valid = 0;
    check({name, " done"}, 128'(done), 128'd1);
    check({name, " idle busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 16; k++) vecs[k] = '{4'(k), k <= 10 ? 128'(k) : 128'h0};
    #2 rst = 1;
    #1;
    check("rst ready", 128'(key_ready), 128'd1);
    check("rst busy", 128'(busy), 128'd0);
    check("rst done", 128'(done), 128'd0);
    check("rst step_round", 128'(step_round), 128'd0);
    check("rst step_key", step_key, 128'h0);
    for (int k = 0; k < 16; k++) rd("rst rd", 4'(k), 128'h0);
    @(negedge clk);
    rst = 0;

    start(128'h0);
    expand("basic", 0);
    for (int k = 0; k < 16; k++) rd("basic rd", vecs[k].addr, vecs[k].exp);

    start({128{1'b1}});
    expand("wrap", 0);
    rd("wrap e0", 4'd0, {128{1'b1}});
    rd("wrap e1", 4'd1, 128'h0);
    rd("wrap e10", 4'd10, 128'h9);

    start(128'h100);
    check("restart done drop", 128'(done), 128'd0);
    expand("restart", 0);
    rd("restart e10", 4'd10, 128'h10A);

    start(128'h200);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("abort round3", 128'(step_round), 128'd3);
    clear = 1;
    key_valid = 1;
    key_in = 128'h300;
    @(negedge clk);
    clear = 0;
    key_valid = 0;
    check("abort busy", 128'(busy), 128'd0);
    check("abort done", 128'(done), 128'd0);
    check("abort ready", 128'(key_ready), 128'd1);
    @(negedge clk);
    check("abort stays idle", 128'(busy), 128'd0);
    rd("abort e0", 4'd0, 128'h200);
    for (int k = 1; k <= 10; k++) rd("abort rd", 4'(k), k <= 3 ? 128'h200 + 128'(k) : 128'h100 + 128'(k));

    start(128'h500);
    expand("noise", 1);
    rd("noise e0", 4'd0, 128'h500);
    rd("noise e10", 4'd10, 128'h50A);

    start(128'h700);
    for (int i = 0; i < 4; i++) @(negedge clk);
    rd_addr = 4'd3;
    #2 rst = 1;
    #1;
    check("arst busy", 128'(busy), 128'd0);
    check("arst done", 128'(done), 128'd0);
    check("arst ready", 128'(key_ready), 128'd1);
    check("arst rd", rd_key, 128'h0);
    check("arst step_key", step_key, 128'h0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    check("arst waits idle", 128'(busy), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
